// File: rtl/serial_bus_master_port.sv
// Master end of the single-wire serial data bus: accepts one parallel core request at a time,
// drives address/write_en in parallel and moves one data byte over data_bus_serial.
module serial_bus_master_port #(
    parameter int ADDRESS_WIDTH = 12,
    parameter int DATA_WIDTH    = 8,
    parameter int TIMEOUT       = 255
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     req_valid,
    input  logic                     req_write,
    input  logic [ADDRESS_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0]    req_wdata,
    output logic                     req_ready,
    output logic                     rsp_valid,
    output logic [DATA_WIDTH-1:0]    rsp_rdata,
    output logic                     rsp_timeout,
    output logic [ADDRESS_WIDTH-1:0] bus_addr,
    output logic                     bus_write_en,
    input  logic                     slave_ready,
    input  logic                     slave_done,
    inout  wire                      data_bus_serial
);

    localparam int CW = $clog2(DATA_WIDTH + 1);
    localparam int TW = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT_RDY,
        S_TX_START,
        S_TX_DATA,
        S_WAIT_DONE,
        S_RX_WAIT,
        S_RX_DATA,
        S_RESP
    } state_t;

    state_t                   state_reg, state_next;
    logic [ADDRESS_WIDTH-1:0] addr_reg, addr_next;
    logic                     write_reg, write_next;
    logic [DATA_WIDTH-1:0]    shift_reg, shift_next;
    logic [DATA_WIDTH-1:0]    rdata_reg, rdata_next;
    logic [CW-1:0]            bit_cnt_reg, bit_cnt_next;
    logic [TW-1:0]            tmo_cnt_reg, tmo_cnt_next;
    logic                     timeout_reg, timeout_next;

    logic line_in;
    logic line_oe;
    logic line_out;
    logic tmo_expired;

    assign line_in     = data_bus_serial;
    assign tmo_expired = (tmo_cnt_reg == TW'(TIMEOUT - 1));

    // The line is only ever driven while a write frame is going out; otherwise the pull-up owns it.
    assign line_oe         = (state_reg == S_TX_START) || (state_reg == S_TX_DATA);
    assign line_out        = (state_reg == S_TX_DATA) ? shift_reg[0] : 1'b0;
    assign data_bus_serial = line_oe ? line_out : 1'bz;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg   <= S_IDLE;
            addr_reg    <= '0;
            write_reg   <= 1'b0;
            shift_reg   <= '0;
            rdata_reg   <= '0;
            bit_cnt_reg <= '0;
            tmo_cnt_reg <= '0;
            timeout_reg <= 1'b0;
        end else begin
            state_reg   <= state_next;
            addr_reg    <= addr_next;
            write_reg   <= write_next;
            shift_reg   <= shift_next;
            rdata_reg   <= rdata_next;
            bit_cnt_reg <= bit_cnt_next;
            tmo_cnt_reg <= tmo_cnt_next;
            timeout_reg <= timeout_next;
        end
    end

    always_comb begin
        state_next   = state_reg;
        addr_next    = addr_reg;
        write_next   = write_reg;
        shift_next   = shift_reg;
        rdata_next   = rdata_reg;
        bit_cnt_next = bit_cnt_reg;
        tmo_cnt_next = tmo_cnt_reg;
        timeout_next = timeout_reg;

        case (state_reg)
            S_IDLE: begin
                if (req_valid) begin
                    addr_next    = req_addr;
                    write_next   = req_write;
                    shift_next   = req_wdata;
                    tmo_cnt_next = '0;
                    timeout_next = 1'b0;
                    state_next   = S_WAIT_RDY;
                end
            end
            S_WAIT_RDY: begin
                if (slave_ready) begin
                    tmo_cnt_next = '0;
                    bit_cnt_next = '0;
                    state_next   = write_reg ? S_TX_START : S_RX_WAIT;
                end else if (tmo_expired) begin
                    timeout_next = 1'b1;
                    state_next   = S_RESP;
                end else begin
                    tmo_cnt_next = tmo_cnt_reg + 1'b1;
                end
            end
            S_TX_START: begin
                bit_cnt_next = '0;
                state_next   = S_TX_DATA;
            end
            S_TX_DATA: begin
                shift_next   = shift_reg >> 1;
                bit_cnt_next = bit_cnt_reg + 1'b1;
                if (bit_cnt_reg == CW'(DATA_WIDTH - 1)) begin
                    tmo_cnt_next = '0;
                    state_next   = S_WAIT_DONE;
                end
            end
            S_WAIT_DONE: begin
                if (slave_done) begin
                    state_next = S_RESP;
                end else if (tmo_expired) begin
                    timeout_next = 1'b1;
                    state_next   = S_RESP;
                end else begin
                    tmo_cnt_next = tmo_cnt_reg + 1'b1;
                end
            end
            S_RX_WAIT: begin
                if (!line_in) begin
                    bit_cnt_next = '0;
                    state_next   = S_RX_DATA;
                end else if (tmo_expired) begin
                    timeout_next = 1'b1;
                    state_next   = S_RESP;
                end else begin
                    tmo_cnt_next = tmo_cnt_reg + 1'b1;
                end
            end
            S_RX_DATA: begin
                // LSB arrives first, so each new bit enters at the top and walks down.
                shift_next   = {line_in, shift_reg[DATA_WIDTH-1:1]};
                bit_cnt_next = bit_cnt_reg + 1'b1;
                if (bit_cnt_reg == CW'(DATA_WIDTH - 1)) begin
                    rdata_next = {line_in, shift_reg[DATA_WIDTH-1:1]};
                    state_next = S_RESP;
                end
            end
            S_RESP: begin
                write_next = 1'b0;
                state_next = S_IDLE;
            end
            default: state_next = S_IDLE;
        endcase
    end

    assign req_ready    = (state_reg == S_IDLE);
    assign rsp_valid    = (state_reg == S_RESP);
    assign rsp_timeout  = (state_reg == S_RESP) && timeout_reg;
    assign rsp_rdata    = rdata_reg;
    assign bus_addr     = addr_reg;
    assign bus_write_en = write_reg;

endmodule

// File: tb/tb_serial_bus_master_port.sv
// Bench for serial_bus_master_port: per-cycle stimulus and expectations are planned up front
// from a transaction-level timeline, then one process drives and one process compares.
module tb_serial_bus_master_port;

    localparam int AW   = 12;
    localparam int DW   = 8;
    localparam int TMO  = 255;
    localparam int MAXC = 2048;

    logic          clk;
    logic          rst;
    logic          req_valid;
    logic          req_write;
    logic [AW-1:0] req_addr;
    logic [DW-1:0] req_wdata;
    logic          req_ready;
    logic          rsp_valid;
    logic [DW-1:0] rsp_rdata;
    logic          rsp_timeout;
    logic [AW-1:0] bus_addr;
    logic          bus_write_en;
    logic          slave_ready;
    logic          slave_done;
    wire           data_bus_serial;
    logic          sl_en;
    logic          sl_bit;

    assign data_bus_serial = sl_en ? sl_bit : 1'bz;
    pullup (data_bus_serial);

    serial_bus_master_port #(
        .ADDRESS_WIDTH(AW),
        .DATA_WIDTH   (DW),
        .TIMEOUT      (TMO)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .req_valid      (req_valid),
        .req_write      (req_write),
        .req_addr       (req_addr),
        .req_wdata      (req_wdata),
        .req_ready      (req_ready),
        .rsp_valid      (rsp_valid),
        .rsp_rdata      (rsp_rdata),
        .rsp_timeout    (rsp_timeout),
        .bus_addr       (bus_addr),
        .bus_write_en   (bus_write_en),
        .slave_ready    (slave_ready),
        .slave_done     (slave_done),
        .data_bus_serial(data_bus_serial)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Stimulus timeline (rst code: 1 = whole cycle, 2 = asserted mid-cycle)
    bit            st_valid [MAXC];
    bit            st_write [MAXC];
    logic [AW-1:0] st_addr  [MAXC];
    logic [DW-1:0] st_wdata [MAXC];
    int            st_rst   [MAXC];
    bit            sl_ready_a [MAXC];
    bit            sl_done_a  [MAXC];
    bit            sl_en_a    [MAXC];
    bit            sl_bit_a   [MAXC];

    // Expected outputs per cycle
    bit            e_ready   [MAXC];
    bit            e_valid   [MAXC];
    bit            e_to      [MAXC];
    bit            e_wen     [MAXC];
    bit            e_wen_chk [MAXC];
    bit            e_line    [MAXC];
    logic [DW-1:0] e_rdata   [MAXC];
    logic [AW-1:0] e_addr    [MAXC];

    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_rdata;
    int            nxt;
    int            end_cyc;
    int            cyc;
    bit            plan_done;
    int            n_cmp;
    int            n_err;
    int            w1_acc, rd_acc, tmo_acc, rst_c;
    logic [8:0]    cap;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s cyc=%0d got=%0h want=%0h", name, cyc, act, exp);
        end
    endtask

    // Bus idle from cycle 'from' onwards: nothing driven, held values kept.
    task automatic plan_idle(input int from);
        for (int c = from; c < MAXC; c++) begin
            st_valid[c] = 0; st_write[c] = 0; st_addr[c] = '0; st_wdata[c] = '0; st_rst[c] = 0;
            sl_ready_a[c] = 0; sl_done_a[c] = 0; sl_en_a[c] = 0; sl_bit_a[c] = 0;
            e_ready[c] = 1; e_valid[c] = 0; e_to[c] = 0; e_wen[c] = 0; e_wen_chk[c] = 1;
            e_line[c] = 1; e_rdata[c] = m_rdata; e_addr[c] = m_addr;
        end
    endtask

    // One request presented at cycle nxt. r/d/k = slave ready delay, done delay, read idle
    // cycles before start bit; negative or >= TMO means the event never arrives in time.
    task automatic plan_txn(input bit wr, input logic [AW-1:0] addr, input logic [DW-1:0] wdata,
                            input int r, input int d, input int k, input logic [DW-1:0] rbits,
                            output int resp);
        int a, e, s, w, e2, dfrom;
        bit to;
        a = nxt; e = a + 1; to = 0; resp = 0; s = 0; w = 0; e2 = 0;
        st_valid[a] = 1; st_write[a] = wr; st_addr[a] = addr; st_wdata[a] = wdata;
        if (r < 0 || r >= TMO) begin
            resp = e + TMO; to = 1;
        end else if (wr) begin
            s = e + r + 1;
            e_line[s] = 0;
            for (int i = 0; i < DW; i++) e_line[s + 1 + i] = wdata[i];
            e2 = s + DW + 1;
            if (d < 0 || d >= TMO) begin
                resp = e2 + TMO; to = 1;
            end else begin
                resp = e2 + d + 1;
                dfrom = (d == 0) ? e : e2 + d;
                for (int c = dfrom; c <= resp; c++) sl_done_a[c] = 1;
            end
        end else begin
            w = e + r + 1;
            if (k < 0 || k >= TMO) begin
                resp = w + TMO; to = 1;
            end else begin
                sl_en_a[w + k] = 1; sl_bit_a[w + k] = 0; e_line[w + k] = 0;
                for (int i = 0; i < DW; i++) begin
                    sl_en_a[w + k + 1 + i] = 1;
                    sl_bit_a[w + k + 1 + i] = rbits[i];
                    e_line[w + k + 1 + i] = rbits[i];
                end
                resp = w + k + DW + 1;
            end
        end
        if (r >= 0 && r < TMO)
            for (int c = e + r; c <= resp; c++) sl_ready_a[c] = 1;
        for (int c = e; c <= resp; c++) begin
            e_ready[c] = 0; e_addr[c] = addr; e_wen[c] = wr; e_wen_chk[c] = (c != resp);
        end
        e_valid[resp] = 1;
        e_to[resp] = to;
        if (!wr && !to) m_rdata = rbits;
        e_rdata[resp] = m_rdata;
        m_addr = addr;
        plan_idle(resp + 1);
        nxt = resp + 3;
    endtask

    task automatic apply(input int c);
        rst = (st_rst[c] == 1);
        req_valid = st_valid[c]; req_write = st_write[c]; req_addr = st_addr[c]; req_wdata = st_wdata[c];
        slave_ready = sl_ready_a[c]; slave_done = sl_done_a[c];
        sl_en = sl_en_a[c]; sl_bit = sl_bit_a[c];
    endtask

    // Driver: builds the plan, then replays it one cycle at a time.
    initial begin
        int resp, a1, a2, junk;
        plan_done = 0; n_cmp = 0; n_err = 0; cyc = 0; cap = '0;
        m_addr = '0; m_rdata = '0;
        plan_idle(0);
        st_rst[0] = 1; st_rst[1] = 1; st_rst[2] = 1;
        nxt = 5;

        w1_acc = nxt;
        plan_txn(1, 12'h0A5, 8'h3C, 0, 0, 0, 8'h00, resp);
        rd_acc = nxt;
        plan_txn(0, 12'h7FF, 8'h00, 0, 0, 3, 8'hA5, resp);
        plan_txn(1, 12'h123, 8'h5A, 2, 3, 0, 8'h00, resp);
        tmo_acc = nxt;
        plan_txn(0, 12'h456, 8'h00, -1, 0, 0, 8'h00, resp);
        plan_txn(0, 12'h789, 8'h00, 0, 0, -1, 8'h00, resp);
        plan_txn(1, 12'h0F0, 8'h96, 0, -1, 0, 8'h00, resp);
        plan_txn(0, 12'h333, 8'h00, TMO - 1, 0, 0, 8'h81, resp);

        // Reset lands while data bit 4 of a write is on the line.
        a1 = nxt;
        plan_txn(1, 12'h555, 8'hC3, 0, 0, 0, 8'h00, resp);
        rst_c = a1 + 7;
        m_addr = '0; m_rdata = '0;
        plan_idle(rst_c);
        st_rst[rst_c] = 2; st_rst[rst_c + 1] = 1;
        nxt = rst_c + 3;
        plan_txn(1, 12'h2AA, 8'h69, 0, 0, 0, 8'h00, resp);

        // Back-to-back writes with req_valid held, then stray pulses while busy.
        a1 = nxt;
        plan_txn(1, 12'h010, 8'h11, 0, 0, 0, 8'h00, resp);
        a2 = resp + 1;
        for (int c = a1 + 1; c <= resp; c++) begin
            st_valid[c] = 1; st_write[c] = 1; st_addr[c] = 12'h020; st_wdata[c] = 8'hEE;
        end
        nxt = a2;
        plan_txn(1, 12'h020, 8'hEE, 0, 0, 0, 8'h00, resp);
        junk = a2 + 3;
        st_valid[junk] = 1; st_addr[junk] = 12'h3FF;
        st_valid[junk + 3] = 1; st_write[junk + 3] = 1; st_addr[junk + 3] = 12'h3FE; st_wdata[junk + 3] = 8'h77;

        end_cyc = nxt + 4;
        if (end_cyc >= MAXC) begin
            $display("FAIL plan_length cyc=%0d got=%0d want<%0d", 0, end_cyc, MAXC);
            $fatal(1, "plan too long");
        end
        plan_done = 1;

        apply(0);
        while (cyc < end_cyc) begin
            @(posedge clk);
            cyc = cyc + 1;
            #1;
            apply(cyc);
            #2;
            if (st_rst[cyc] == 2) rst = 1;
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    // Compare process: every cycle against the plan, plus a few hand-derived pins.
    always @(negedge clk) begin
        if (plan_done && cyc >= 1 && cyc < end_cyc) begin
            chk("req_ready", req_ready, e_ready[cyc]);
            chk("rsp_valid", rsp_valid, e_valid[cyc]);
            if (e_valid[cyc]) chk("rsp_timeout", rsp_timeout, e_to[cyc]);
            chk("rsp_rdata", rsp_rdata, e_rdata[cyc]);
            chk("bus_addr", bus_addr, e_addr[cyc]);
            if (e_wen_chk[cyc]) chk("bus_write_en", bus_write_en, e_wen[cyc]);
            chk("line", data_bus_serial, e_line[cyc]);

            if (cyc >= w1_acc + 2 && cyc <= w1_acc + 10) cap = {cap[7:0], data_bus_serial};
            if (cyc == w1_acc + 10) chk("pin_w1_frame", cap, 9'b000111100);
            if (cyc == w1_acc + 12) chk("pin_w1_rsp_at_4+DW", rsp_valid, 1'b1);
            if (cyc == rd_acc + 14) chk("pin_rd_rdata", {rsp_valid, rsp_rdata}, 9'h1A5);
            if (cyc == tmo_acc + 1 + TMO) chk("pin_tmo_rsp", {rsp_valid, rsp_timeout}, 2'b11);
            if (cyc == tmo_acc + 2 + TMO) chk("pin_tmo_ready", req_ready, 1'b1);
            if (cyc == rst_c) chk("pin_rst_async", {req_ready, bus_write_en, bus_addr}, {2'b10, 12'h000});

            if (rsp_valid)
                $display("txn cyc=%0d addr=%03h we=%0b timeout=%0b rdata=%02h",
                         cyc, bus_addr, bus_write_en, rsp_timeout, rsp_rdata);
        end
    end

endmodule
